// File: rtl/tsc_capture_sequencer.sv
// Trigger-surround capture sequencer: ADC handshake, ring-buffer writes, pre/post
// trigger windows, threshold trigger with timestamp, and hand-off to serial readout.
module tsc_capture_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_W-1:0]  threshold,
  input  logic [ADDR_W-1:0]  pre_samples,
  output logic               adc_req,
  input  logic               adc_ack,
  input  logic [DATA_W-1:0]  adc_data,
  output logic               buf_we,
  output logic [ADDR_W-1:0]  buf_waddr,
  output logic [DATA_W-1:0]  buf_wdata,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_base,
  input  logic               rd_done,
  output logic               trd,
  output logic [TIMER_W-1:0] trigtm,
  output logic               cd,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_ARMED, S_POST, S_READOUT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_IDX = '1;

  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_wptr, r_fill_cnt, r_post_cnt, r_pre_sat;
  logic [DATA_W-1:0]    r_thr;
  logic [TIMER_W-1:0]   r_timer, r_trigtm;
  logic                 r_trd;

  logic                 w_accept, w_hit, w_arm;
  logic [ADDR_W-1:0]    w_fill_next, w_post_init, w_pre_sat;

  // pre_samples is ADDR_W wide, so it can never exceed DEPTH-1: the clamp is the identity.
  assign w_pre_sat   = pre_samples;
  assign w_accept    = adc_req & adc_ack;
  assign w_hit       = w_accept && (adc_data >= r_thr);
  assign w_arm       = start & ~abort;
  assign w_fill_next = r_fill_cnt + 1'b1;
  assign w_post_init = MAX_IDX - r_pre_sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    adc_req = 1'b0;
    rd_req  = 1'b0;
    cd      = 1'b0;
    rd_base = '0;
    case (r_state)
      S_IDLE: begin
        if (w_arm) w_next = (w_pre_sat == '0) ? S_ARMED : S_PREFILL;
      end
      S_PREFILL: begin
        adc_req = 1'b1;
        if (w_accept && (w_fill_next == r_pre_sat)) w_next = S_ARMED;
      end
      S_ARMED: begin
        adc_req = 1'b1;
        if (w_hit) w_next = (w_post_init == '0) ? S_READOUT : S_POST;
      end
      S_POST: begin
        adc_req = 1'b1;
        if (w_accept && (r_post_cnt == ADDR_W'(1))) w_next = S_READOUT;
      end
      S_READOUT: begin
        rd_req  = 1'b1;
        rd_base = r_wptr;
        if (rd_done) w_next = S_DONE;
      end
      S_DONE: begin
        cd     = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // abort overrides every transition chosen above
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_fill_cnt <= '0;
      r_post_cnt <= '0;
      r_pre_sat  <= '0;
      r_thr      <= '0;
      r_timer    <= '0;
      r_trigtm   <= '0;
      r_trd      <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_arm) begin
        r_thr      <= threshold;
        r_pre_sat  <= w_pre_sat;
        r_wptr     <= '0;
        r_fill_cnt <= '0;
        r_post_cnt <= '0;
        r_timer    <= '0;
        r_trigtm   <= '0;
        r_trd      <= 1'b0;
      end
    end else if (abort) begin
      r_trd <= 1'b0;
    end else begin
      if (r_timer != '1) r_timer <= r_timer + 1'b1;
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if ((r_state == S_PREFILL) && w_accept) r_fill_cnt <= w_fill_next;
      if ((r_state == S_ARMED) && w_hit) begin
        r_trigtm   <= r_timer;
        r_trd      <= 1'b1;
        r_post_cnt <= w_post_init;
      end
      if ((r_state == S_POST) && w_accept) r_post_cnt <= r_post_cnt - 1'b1;
    end
  end

  assign buf_we    = w_accept;
  assign buf_waddr = r_wptr;
  assign buf_wdata = w_accept ? adc_data : '0;
  assign trd       = r_trd;
  assign trigtm    = r_trigtm;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_tsc_capture_sequencer.sv
// Directed bench for tsc_capture_sequencer: capture scenarios with hand-computed
// trigger timestamps, write counts, readout base and buffer contents.
module tb_tsc_capture_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  threshold = '0;
  logic [4:0]  pre_samples = '0;
  logic        adc_req;
  logic        adc_ack = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        buf_we;
  logic [4:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic        rd_req;
  logic [4:0]  rd_base;
  logic        rd_done = 1'b0;
  logic        trd;
  logic [31:0] trigtm;
  logic        cd;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int wr_cnt, bad_addr, bad_we;
  bit to_flag;
  logic [7:0] mem [32];

  tsc_capture_sequencer #(.DATA_W(8), .ADDR_W(5), .TIMER_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .threshold(threshold), .pre_samples(pre_samples),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .rd_req(rd_req), .rd_base(rd_base), .rd_done(rd_done),
    .trd(trd), .trigtm(trigtm), .cd(cd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [4:0] pre, input logic [7:0] thr);
    @(negedge clk);
    pre_samples = pre;
    threshold   = thr;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    pre_samples = 5'd0;
    threshold   = 8'hFF;
  endtask

  // Feeds sample k on the k-th accept; stops at readout or after stop_at writes.
  task automatic run_capture(input int period, input int stop_at, input int restart_at);
    wr_cnt = 0; bad_addr = 0; bad_we = 0; to_flag = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      start = (n == restart_at);
      if (n == restart_at) begin pre_samples = 5'd0; threshold = 8'h00; end
      adc_ack  = ((n % period) == 0);
      adc_data = wr_cnt[7:0];
      #1;
      if (rd_req) begin to_flag = 1'b0; break; end
      if (buf_we) begin
        if (!adc_ack) bad_we++;
        if (buf_waddr != wr_cnt[4:0]) bad_addr++;
        mem[buf_waddr] = buf_wdata;
        wr_cnt++;
      end
      @(negedge clk);
      if (wr_cnt >= stop_at) begin to_flag = 1'b0; break; end
    end
    start = 1'b0; adc_ack = 1'b0; threshold = 8'hFF;
  endtask

  task automatic check_capture(input string nm, input int exp_wr, input logic [31:0] exp_tm,
                               input logic [4:0] exp_base, input logic [7:0] exp_old);
    checks++; if (to_flag) begin errors++; $display("FAIL %s timeout: readout never reached", nm); end
    checks++; if (wr_cnt !== exp_wr) begin errors++; $display("FAIL %s writes: got %0d want %0d", nm, wr_cnt, exp_wr); end
    checks++; if (trigtm !== exp_tm) begin errors++; $display("FAIL %s trigtm: got %0d want %0d", nm, trigtm, exp_tm); end
    checks++; if (trd !== 1'b1) begin errors++; $display("FAIL %s trd: got %b want 1", nm, trd); end
    checks++; if (rd_base !== exp_base) begin errors++; $display("FAIL %s rd_base: got %0d want %0d", nm, rd_base, exp_base); end
    checks++; if (mem[exp_base] !== exp_old) begin errors++; $display("FAIL %s oldest: got %h want %h", nm, mem[exp_base], exp_old); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL %s waddr: got %0d bad want 0", nm, bad_addr); end
    checks++; if (bad_we !== 0) begin errors++; $display("FAIL %s we_no_ack: got %0d want 0", nm, bad_we); end
  endtask

  task automatic finish_readout(input string nm);
    @(negedge clk);
    rd_done = 1'b1;
    #1;
    checks++; if ({rd_req, cd} !== 2'b10) begin errors++; $display("FAIL %s pre_done rd_req,cd: got %b want 10", nm, {rd_req, cd}); end
    @(negedge clk);
    rd_done = 1'b0;
    #1;
    checks++; if ({cd, rd_req, busy} !== 3'b101) begin errors++; $display("FAIL %s done cd,rd_req,busy: got %b want 101", nm, {cd, rd_req, busy}); end
    @(negedge clk);
    #1;
    checks++; if ({cd, busy, trd} !== 3'b001) begin errors++; $display("FAIL %s idle cd,busy,trd: got %b want 001", nm, {cd, busy, trd}); end
  endtask

  task automatic check_all_zero(input string nm);
    logic [48:0] v;
    v = {adc_req, buf_we, buf_waddr, buf_wdata, rd_req, rd_base, trd, trigtm[0], cd, busy};
    checks++; if (v !== '0) begin errors++; $display("FAIL %s outputs: got %h want 0", nm, v); end
    checks++; if (trigtm !== 32'd0) begin errors++; $display("FAIL %s trigtm: got %h want 0", nm, trigtm); end
  endtask

  task automatic test_reset;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    do_start(5'd8, 8'hD5);
    run_capture(1, 100000, -1);
    check_capture("basic", 237, 32'hD5, 5'd13, 8'hCD);
    finish_readout("basic");
  endtask

  task automatic test_zero_pre;
    do_start(5'd0, 8'h00);
    run_capture(1, 100000, -1);
    check_capture("zero_pre", 32, 32'd0, 5'd0, 8'h00);
    finish_readout("zero_pre");
  endtask

  task automatic test_slow_ack;
    do_start(5'd8, 8'hD5);
    run_capture(3, 100000, -1);
    check_capture("slow_ack", 237, 32'd639, 5'd13, 8'hCD);
    finish_readout("slow_ack");
  endtask

  task automatic test_abort;
    int seen;
    seen = 0;
    do_start(5'd8, 8'hD5);
    run_capture(1, 220, -1);
    abort = 1'b1;
    #1;
    checks++; if ({busy, trd} !== 2'b11) begin errors++; $display("FAIL abort pre busy,trd: got %b want 11", {busy, trd}); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++; if ({adc_req, busy, trd, rd_req} !== 4'b0000) begin errors++; $display("FAIL abort post req,busy,trd,rd_req: got %b want 0000", {adc_req, busy, trd, rd_req}); end
    adc_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (adc_req || rd_req || cd || buf_we || busy) seen++;
    end
    adc_ack = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort quiet: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_reset_readout;
    do_start(5'd8, 8'hD5);
    run_capture(1, 100000, -1);
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL rst_ro reached: got %b want 1", rd_req); end
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_ro");
    @(negedge clk);
    reset_n = 1'b1;
    do_start(5'd8, 8'hD5);
    run_capture(1, 100000, -1);
    check_capture("rst_rerun", 237, 32'hD5, 5'd13, 8'hCD);
    finish_readout("rst_rerun");
  endtask

  task automatic test_pre_max;
    do_start(5'd31, 8'h40);
    run_capture(1, 100000, 3);
    check_capture("pre_max", 65, 32'd64, 5'd1, 8'h21);
    finish_readout("pre_max");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_pre;
    test_slow_ack;
    test_abort;
    test_reset_readout;
    test_pre_max;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
